inv_clark: RTL and testbench
============================

Name: inv_clark

Overview:
- Inverse Clarke transform: converts a stationary-frame voltage command (Valpha, Vbeta) into three phase voltages (Ua, Ub, Uc). Output feeds the phase-domain PWM stage.
- Counterpart of the forward Clarke block: same fixed-point format, same rising-edge trigger on an enable, same one-cycle done pulse.
- Uses one shared multiplier in a small FSM, so each conversion takes several clocks.

Parameters:
- W, 12, signed width of all voltage inputs and outputs (two's complement)
- FRAC, 10, fractional bits of the coefficient
- COEF, 887, round(sqrt(3)/2 * 2^FRAC), unsigned

Ports:
- iClk  input  1  system clock; all logic on its rising edge
- iRst  input  1  synchronous, active-high reset
- iIC_en  input  1  conversion trigger; a conversion starts on its rising edge
- iValpha  input  W  signed alpha-axis voltage
- iVbeta  input  W  signed beta-axis voltage
- oUa  output  W  signed phase-A voltage
- oUb  output  W  signed phase-B voltage
- oUc  output  W  signed phase-C voltage
- oIC_busy  output  1  high while a conversion is in flight
- oIC_done  output  1  one-cycle pulse; outputs are valid from this cycle onward

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (iRst=1 at a clock edge):
  - oUa, oUb, oUc = 0; oIC_busy = 0; oIC_done = 0.
  - en_prev = 0; FSM goes to IDLE.
  - Overrides everything, including a conversion mid-flight: it is aborted, no done pulse.
- Edge detect:
  - en_prev <= iIC_en every clock.
  - edge = iIC_en & ~en_prev.
  - If iIC_en is high in the first clock after reset, that counts as an edge.
- FSM states: IDLE, MUL, SUM.
  - IDLE:
    - On edge: latch alpha_r <= iValpha, beta_r <= iVbeta; go to MUL.
    - Otherwise stay in IDLE.
  - MUL:
    - prod_r <= beta_r * COEF (signed x unsigned, 2W+1 bits minimum); go to SUM.
  - SUM:
    - p = (prod_r + 2^(FRAC-1)) >>> FRAC, i.e. round half up, arithmetic shift.
    - h = alpha_r >>> 1, i.e. floor division by 2.
    - oUa <= alpha_r.
    - oUb <= sat(-h + p).
    - oUc <= sat(-h - p).
    - oIC_done <= 1; go to IDLE.
- Timing:
  - Edge accepted at clock k; oIC_done high for exactly one cycle, between edges k+2 and k+3.
  - Latency is fixed at 2 clocks; throughput is at most one conversion per 3 clocks.
  - oIC_busy = 1 in MUL and SUM; registered so it is high during the same cycles as those states.
- Arithmetic and width rules:
  - Intermediate sums use at least W+2 bits.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1], i.e. [-2048, 2047] at default.
  - oUa never needs saturation.
- Boundary conditions:
  - Edges arriving in MUL or SUM are ignored; the latched inputs are used.
  - en_prev keeps tracking, so an edge landing in SUM is lost, not deferred.
  - iValpha and iVbeta may change freely after the accepting edge.
  - Outputs hold their last values between conversions; oIC_done is 0 outside SUM->IDLE.

Decomposition:
- Shared FOC package holds:
  - W and FRAC defaults
  - COEF_SQRT3_2 = 887, next to the forward block's 1/sqrt(3) constant 591
  - state enum {IDLE, MUL, SUM}
- Natural sub-module: sat_signed, a parameterised clamp from a wide signed value to W bits.
  - Reused by later Park/inverse-Park blocks.
  - Two instances here (Ub, Uc).

Test Plan:
- Reset values:
  - Stimulus: assert iRst for 2 clocks with iIC_en toggling.
  - Required: all outputs 0, no done pulse.
  - Then: release with iIC_en=0, hold 5 clocks; outputs stay 0.
- Pure alpha:
  - Stimulus: Valpha=1000, Vbeta=0, rising edge.
  - Required: done exactly 2 clocks later with Ua=1000, Ub=-500, Uc=-500; busy high for 2 cycles.
- Pure beta:
  - Stimulus: Valpha=0, Vbeta=1000.
  - Required: prod=887000, p=866, so Ua=0, Ub=866, Uc=-866.
- Odd/negative alpha with saturation:
  - Stimulus: Valpha=-2048, Vbeta=2047.
  - Required: h=-1024, p=1773, Ub clamps to 2047, Uc=-749, Ua=-2048.
  - Stimulus: Valpha=-1, Vbeta=0.
  - Required: Ub=Uc=1.
- Retrigger while busy:
  - Stimulus: second rising edge one clock after the first, with changed inputs.
  - Required: a single done pulse, results from the first inputs only.
  - Then: a new edge after return to IDLE converts normally.
- Reset mid-operation:
  - Stimulus: assert iRst in the MUL cycle.
  - Required: no done pulse, outputs 0, FSM in IDLE.
  - Then: iIC_en held high through release gives one conversion after reset.

Source files
------------

// File: rtl/inv_clark_pkg.sv
// Shared FOC definitions: fixed-point defaults, transform coefficients and the
// conversion sequencer state type used by the Clarke-family blocks.
package inv_clark_pkg;

  localparam int W_DEF    = 12;
  localparam int FRAC_DEF = 10;

  // Q.FRAC coefficients: sqrt(3)/2 for the inverse block, 1/sqrt(3) for the forward one
  localparam int COEF_SQRT3_2   = 887;
  localparam int COEF_INV_SQRT3 = 591;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_SUM  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_MUL  = S_MUL,
    ST_SUM  = S_SUM
  } ic_state_e;

endpackage

// File: rtl/inv_clark_sat.sv
// Signed clamp from an IW-bit value to the OW-bit two's complement range.
module sat_signed #(
  parameter int IW = 14,
  parameter int OW = 12
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [OW-1:0] q_o
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    q_o = d_i[OW-1:0];
    if (d_i > MAXV) begin
      q_o = MAXV[OW-1:0];
    end else if (d_i < MINV) begin
      q_o = MINV[OW-1:0];
    end
  end

endmodule

// File: rtl/inv_clark.sv
// Inverse Clarke transform (alpha, beta) -> (a, b, c) using a single shared
// multiplier; a rising edge on iIC_en starts a fixed two-clock conversion.
module inv_clark
  import inv_clark_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int COEF = COEF_SQRT3_2
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iIC_en,
  input  logic signed [W-1:0] iValpha,
  input  logic signed [W-1:0] iVbeta,
  output logic signed [W-1:0] oUa,
  output logic signed [W-1:0] oUb,
  output logic signed [W-1:0] oUc,
  output logic                oIC_busy,
  output logic                oIC_done
);

  localparam int CW = $clog2(COEF + 1) + 1;
  localparam int PW = W + CW;
  localparam int RW = PW + 1;
  localparam int SW = W + 2;

  localparam logic signed [CW-1:0] COEF_S = CW'(COEF);
  localparam logic signed [RW-1:0] HALF   = {{(RW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  ic_state_e            state_q, state_d;
  logic                 en_prev_q;
  logic signed [W-1:0]  alpha_q, alpha_d;
  logic signed [W-1:0]  beta_q, beta_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [W-1:0]  ua_q, ua_d, ub_q, ub_d, uc_q, uc_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 rise_w;
  logic signed [RW-1:0] rnd_w;
  logic signed [SW-1:0] p_w, h_w, ub_sum_w, uc_sum_w;
  logic signed [W-1:0]  ub_sat_w, uc_sat_w;

  assign rise_w = iIC_en & ~en_prev_q;

  // Round half up, then floor-halve alpha; both are arithmetic shifts of signed values
  assign rnd_w    = RW'(prod_q) + HALF;
  assign p_w      = SW'(rnd_w >>> FRAC);
  assign h_w      = SW'(alpha_q) >>> 1;
  assign ub_sum_w = p_w - h_w;
  assign uc_sum_w = -h_w - p_w;

  sat_signed #(.IW(SW), .OW(W)) u_sat_ub (.d_i(ub_sum_w), .q_o(ub_sat_w));
  sat_signed #(.IW(SW), .OW(W)) u_sat_uc (.d_i(uc_sum_w), .q_o(uc_sat_w));

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    prod_d  = prod_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    uc_d    = uc_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_w) begin
          alpha_d = iValpha;
          beta_d  = iVbeta;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d  = PW'(beta_q) * PW'(COEF_S);
        state_d = ST_SUM;
      end
      ST_SUM: begin
        ua_d    = alpha_q;
        ub_d    = ub_sat_w;
        uc_d    = uc_sat_w;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      en_prev_q <= 1'b0;
      alpha_q   <= '0;
      beta_q    <= '0;
      prod_q    <= '0;
      ua_q      <= '0;
      ub_q      <= '0;
      uc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= iIC_en;
      alpha_q   <= alpha_d;
      beta_q    <= beta_d;
      prod_q    <= prod_d;
      ua_q      <= ua_d;
      ub_q      <= ub_d;
      uc_q      <= uc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign oUa      = ua_q;
  assign oUb      = ub_q;
  assign oUc      = uc_q;
  assign oIC_busy = busy_q;
  assign oIC_done = done_q;

endmodule

// File: tb/tb_inv_clark.sv
// Self-checking bench for inv_clark against an integer reference model of the
// inverse Clarke equations.
module tb_inv_clark;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst, en;
  logic signed [W-1:0] va, vb, ua, ub, uc;
  logic                busy, done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  inv_clark #(.W(W), .FRAC(10), .COEF(887)) dut (
    .iClk(clk), .iRst(rst), .iIC_en(en), .iValpha(va), .iVbeta(vb),
    .oUa(ua), .oUb(ub), .oUc(uc), .oIC_busy(busy), .oIC_done(done)
  );

  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int sat12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Ua = a, Ub = -a/2 + (sqrt3/2) b, Uc = -a/2 - (sqrt3/2) b in Q10 with round-half-up
  task automatic model(input int a, input int b, output int ea, output int eb, output int ec);
    int p, h;
    p  = fdiv(b * 887 + 512, 1024);
    h  = fdiv(a, 2);
    ea = a;
    eb = sat12(p - h);
    ec = sat12(-h - p);
  endtask

  task automatic test_conversion(input int a, input int b, input string name);
    int ea, eb, ec;
    logic signed [W-1:0] xa, xb, xc;
    model(a, b, ea, eb, ec);
    xa = W'(ea); xb = W'(eb); xc = W'(ec);
    @(negedge clk); va = W'(a); vb = W'(b); en = 1'b1;
    @(negedge clk); en = 1'b0; va = W'($urandom); vb = W'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s cyc1: busy=%b done=%b required busy=1 done=0", name, busy, done);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s cyc2: busy=%b done=%b required busy=1 done=0", name, busy, done);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done: busy=%b done=%b required busy=0 done=1", name, busy, done);
    else passes++;
    checks++;
    if (ua !== xa || ub !== xb || uc !== xc)
      $display("FAIL %s result: Ua=%0d Ub=%0d Uc=%0d required %0d %0d %0d",
               name, ua, ub, uc, xa, xb, xc);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ua !== xa || ub !== xb || uc !== xc)
      $display("FAIL %s hold: done=%b Ua=%0d Ub=%0d Uc=%0d required done=0 %0d %0d %0d",
               name, done, ua, ub, uc, xa, xb, xc);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; va = 12'sd100; vb = 12'sd200;
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    checks++;
    if (ua !== '0 || ub !== '0 || uc !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset: Ua=%0d Ub=%0d Uc=%0d busy=%b done=%b required all 0",
               ua, ub, uc, busy, done);
    else passes++;
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ua !== '0 || ub !== '0 || uc !== '0 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL idle_after_reset: Ua=%0d Ub=%0d Uc=%0d busy=%b done=%b required all 0",
                 ua, ub, uc, busy, done);
      else passes++;
    end
  endtask

  task automatic test_retrigger();
    int ea, eb, ec;
    int dones;
    logic signed [W-1:0] xa, xb, xc;
    model(300, -700, ea, eb, ec);
    xa = W'(ea); xb = W'(eb); xc = W'(ec);
    @(negedge clk); va = 12'sd300; vb = -12'sd700; en = 1'b1;
    @(negedge clk); en = 1'b0; va = -12'sd1500; vb = 12'sd1200;
    @(negedge clk); en = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (ua !== xa || ub !== xb || uc !== xc)
          $display("FAIL retrigger result: Ua=%0d Ub=%0d Uc=%0d required %0d %0d %0d",
                   ua, ub, uc, xa, xb, xc);
        else passes++;
      end
    end
    checks++;
    if (dones != 1) $display("FAIL retrigger pulses: got %0d required 1", dones);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL retrigger deferred: busy=%b required 0", busy);
    else passes++;
    test_conversion(-900, 450, "after_retrigger");
  endtask

  task automatic test_reset_mid();
    int ea, eb, ec;
    int dones;
    logic signed [W-1:0] xa, xb, xc;
    @(negedge clk); va = 12'sd1234; vb = 12'sd999; en = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ua !== '0 || ub !== '0 || uc !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid: Ua=%0d Ub=%0d Uc=%0d busy=%b done=%b required all 0",
               ua, ub, uc, busy, done);
    else passes++;
    model(-600, 800, ea, eb, ec);
    xa = W'(ea); xb = W'(eb); xc = W'(ec);
    rst = 1'b0; va = -12'sd600; vb = 12'sd800;
    dones = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (busy !== 1'b1 || dones != 0)
      $display("FAIL reset_mid restart: busy=%b early_dones=%0d required busy=1 dones=0", busy, dones);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ua !== xa || ub !== xb || uc !== xc)
      $display("FAIL reset_mid result: done=%b Ua=%0d Ub=%0d Uc=%0d required done=1 %0d %0d %0d",
               done, ua, ub, uc, xa, xb, xc);
    else passes++;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL reset_mid pulse: done=%b required 0", done);
    else passes++;
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(4095)) - 2048;
      b = int'($urandom_range(4095)) - 2048;
      test_conversion(a, b, "random");
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; va = '0; vb = '0;
    test_reset();
    test_conversion(1000, 0, "pure_alpha");
    test_conversion(0, 1000, "pure_beta");
    test_conversion(-2048, 2047, "sat_high");
    test_conversion(-1, 0, "odd_neg_alpha");
    test_conversion(2047, -2048, "sat_low");
    test_conversion(-2048, -2048, "both_min");
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
